fault_mem_cfg: RTL

Behavioural memory model with run-time programmable fault injection, for exercising the MBIST controller and its march algorithms.
- Generalises the single-address hard-coded neighbourhood-fault memory to NUM_FAULTS independent fault slots.
- Each slot is programmable for address, bit and fault type: stuck-at, transition, coupling or neighbourhood-pattern-sensitive.
- Sits in the place of the macro under test in the BIST test bench and in the gate-level harness.

---
 rtl/fault_mem_cfg.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fault_mem_cfg.sv
// Behavioural word memory with NUM_FAULTS run-time programmable fault slots
// (stuck-at, transition, coupling, NPSF) and a two-stage registered read path.
module fault_mem_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CAPACITY   = 64,
    parameter int NUM_FAULTS = 2,
    localparam int SEL_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  cfg_we,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic                  cfg_en,
    input  logic [2:0]            cfg_type,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [BIT_W-1:0]      cfg_bit,
    input  logic [ADDR_WIDTH-1:0] cfg_aggr_addr,
    input  logic [BIT_W-1:0]      cfg_aggr_bit,
    output logic                  fault_hit
);

    typedef enum logic [2:0] {
        FT_NONE  = 3'd0,
        FT_SA0   = 3'd1,
        FT_SA1   = 3'd2,
        FT_TF_UP = 3'd3,
        FT_TF_DN = 3'd4,
        FT_CFIN  = 3'd5,
        FT_CFID  = 3'd6,
        FT_NPSF  = 3'd7
    } fault_type_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);
    localparam logic [ADDR_WIDTH:0]   CAP_EXT   = (ADDR_WIDTH + 1)'(CAPACITY);

    logic [DATA_WIDTH-1:0] mem [0:CAPACITY-1];

    logic [NUM_FAULTS-1:0] slot_en_reg;
    fault_type_t           slot_type_reg      [NUM_FAULTS];
    logic [ADDR_WIDTH-1:0] slot_addr_reg      [NUM_FAULTS];
    logic [BIT_W-1:0]      slot_bit_reg       [NUM_FAULTS];
    logic [ADDR_WIDTH-1:0] slot_aggr_addr_reg [NUM_FAULTS];
    logic [BIT_W-1:0]      slot_aggr_bit_reg  [NUM_FAULTS];

    logic [DATA_WIDTH-1:0] stage1_reg;
    logic                  stage1_vld_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  fault_hit_reg;

    logic [NUM_FAULTS-1:0] victim_ok;
    logic [NUM_FAULTS-1:0] victim_bit;
    logic [NUM_FAULTS-1:0] nb_up_bit;
    logic [NUM_FAULTS-1:0] nb_dn_bit;

    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [NUM_FAULTS-1:0] cpl_act;
    logic [NUM_FAULTS-1:0] cpl_val;
    logic                  remote_chg;
    logic                  wr_hit;
    logic                  rd_hit;
    logic                  vhit;
    logic                  ahit;
    logic [BIT_W-1:0]      vb;
    logic [BIT_W-1:0]      ab;

    // Slot configuration registers; an unmatched cfg_sel simply loads nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_en_reg <= '0;
            for (int s = 0; s < NUM_FAULTS; s++) begin
                slot_type_reg[s]      <= FT_NONE;
                slot_addr_reg[s]      <= '0;
                slot_bit_reg[s]       <= '0;
                slot_aggr_addr_reg[s] <= '0;
                slot_aggr_bit_reg[s]  <= '0;
            end
        end else if (cfg_we) begin
            for (int s = 0; s < NUM_FAULTS; s++) begin
                if (cfg_sel == SEL_W'(s)) begin
                    slot_en_reg[s]        <= cfg_en;
                    slot_type_reg[s]      <= fault_type_t'(cfg_type);
                    slot_addr_reg[s]      <= cfg_addr;
                    slot_bit_reg[s]       <= cfg_bit;
                    slot_aggr_addr_reg[s] <= cfg_aggr_addr;
                    slot_aggr_bit_reg[s]  <= cfg_aggr_bit;
                end
            end
        end
    end

    // Per-slot views of the victim bit and its NPSF neighbours (wrapping).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FAULTS; gi++) begin : g_slot
            logic [ADDR_WIDTH-1:0] up_addr;
            logic [ADDR_WIDTH-1:0] dn_addr;
            assign up_addr = (slot_addr_reg[gi] == LAST_ADDR) ? '0
                           : slot_addr_reg[gi] + ADDR_WIDTH'(1);
            assign dn_addr = (slot_addr_reg[gi] == '0) ? LAST_ADDR
                           : slot_addr_reg[gi] - ADDR_WIDTH'(1);
            assign victim_ok[gi]  = ({1'b0, slot_addr_reg[gi]} < CAP_EXT);
            assign victim_bit[gi] = victim_ok[gi] ? mem[slot_addr_reg[gi]][slot_bit_reg[gi]] : 1'b0;
            assign nb_up_bit[gi]  = victim_ok[gi] ? mem[up_addr][slot_bit_reg[gi]] : 1'b0;
            assign nb_dn_bit[gi]  = victim_ok[gi] ? mem[dn_addr][slot_bit_reg[gi]] : 1'b0;
        end
    endgenerate

    // Slots applied in ascending order so the highest enabled index wins a shared bit.
    always_comb begin
        addr_ok    = ({1'b0, address} < CAP_EXT);
        old_word   = addr_ok ? mem[address] : '0;
        wr_word    = wdata;
        rd_word    = old_word;
        cpl_act    = '0;
        cpl_val    = '0;
        remote_chg = 1'b0;
        vhit       = 1'b0;
        ahit       = 1'b0;
        vb         = '0;
        ab         = '0;
        for (int s = 0; s < NUM_FAULTS; s++) begin
            if (slot_en_reg[s]) begin
                vb   = slot_bit_reg[s];
                ab   = slot_aggr_bit_reg[s];
                vhit = (address == slot_addr_reg[s]);
                ahit = (address == slot_aggr_addr_reg[s]);
                case (slot_type_reg[s])
                    FT_SA0: begin
                        if (vhit) begin
                            wr_word[vb] = 1'b0;
                            rd_word[vb] = 1'b0;
                        end
                    end
                    FT_SA1: begin
                        if (vhit) begin
                            wr_word[vb] = 1'b1;
                            rd_word[vb] = 1'b1;
                        end
                    end
                    FT_TF_UP: begin
                        if (vhit && !old_word[vb] && wr_word[vb]) wr_word[vb] = 1'b0;
                    end
                    FT_TF_DN: begin
                        if (vhit && old_word[vb] && !wr_word[vb]) wr_word[vb] = 1'b1;
                    end
                    FT_CFIN: begin
                        if (ahit && (old_word[ab] != wr_word[ab])) begin
                            if (vhit) begin
                                wr_word[vb] = ~wr_word[vb];
                            end else if (victim_ok[s]) begin
                                cpl_act[s] = 1'b1;
                                cpl_val[s] = ~victim_bit[s];
                            end
                        end
                    end
                    FT_CFID: begin
                        if (ahit && !old_word[ab] && wr_word[ab]) begin
                            if (vhit) begin
                                wr_word[vb] = 1'b1;
                            end else if (victim_ok[s]) begin
                                cpl_act[s] = 1'b1;
                                cpl_val[s] = 1'b1;
                            end
                        end
                    end
                    FT_NPSF: begin
                        if (vhit && !nb_up_bit[s] && nb_dn_bit[s]) wr_word[vb] = old_word[vb];
                    end
                    default: ;
                endcase
                if (cpl_act[s] && (cpl_val[s] != victim_bit[s])) remote_chg = 1'b1;
            end
        end
        wr_hit = (wr_word != wdata) || remote_chg;
        rd_hit = (rd_word != old_word);
    end

    // Array is deliberately left unreset; coupled victims in other words update alongside.
    always_ff @(posedge clk) begin
        if (rst_n && write_read && addr_ok) begin
            mem[address] <= wr_word;
            for (int s = 0; s < NUM_FAULTS; s++) begin
                if (cpl_act[s]) mem[slot_addr_reg[s]][slot_bit_reg[s]] <= cpl_val[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1_reg     <= '0;
            stage1_vld_reg <= 1'b0;
            rdata_reg      <= '0;
            fault_hit_reg  <= 1'b0;
        end else begin
            fault_hit_reg  <= 1'b0;
            stage1_vld_reg <= 1'b0;
            if (stage1_vld_reg) rdata_reg <= stage1_reg;
            if (addr_ok) begin
                if (write_read) begin
                    fault_hit_reg <= wr_hit;
                end else begin
                    stage1_reg     <= rd_word;
                    stage1_vld_reg <= 1'b1;
                    fault_hit_reg  <= rd_hit;
                end
            end
        end
    end

    assign rdata     = rdata_reg;
    assign fault_hit = fault_hit_reg;

endmodule
